// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
// Holds the fetch FSM encoding and the small helpers used by the PC datapath.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump, taken branch-if-equal, or sequential.
// The result is always word aligned; all arithmetic wraps modulo 2^N.
module next_pc_calc #(
  parameter int N = 32
) (
  input  logic [N-1:0] pc_plus4,
  input  logic [N-1:0] ext_imm,
  input  logic         branch,
  input  logic         zero,
  input  logic         jump,
  input  logic [25:0]  jump_target,
  output logic [N-1:0] next_pc
);

  logic [N-1:0] jump_pc;
  logic [N-1:0] branch_pc;
  logic [N-1:0] sel_pc;

  // The word offset drops the two top immediate bits; shifting keeps the full
  // immediate referenced while producing {ext_imm[N-3:0], 2'b00}.
  assign jump_pc   = {pc_plus4[N-1:28], jump_target, 2'b00};
  assign branch_pc = pc_plus4 + (ext_imm << 2);

  always_comb begin
    if (jump) begin
      sel_pc = jump_pc;
    end else if (branch && zero) begin
      sel_pc = branch_pc;
    end else begin
      sel_pc = pc_plus4;
    end
  end

  assign next_pc = {sel_pc[N-1:2], 2'b00};

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch controller: fetches over a req/ack
// handshake with a bounded wait, then holds the instruction for execute.
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           TIMEOUT  = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ext_imm,
  input  logic         branch,
  input  logic         zero,
  input  logic         jump,
  input  logic [25:0]  jump_target,
  input  logic         stall,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic         fetch_err
);

  localparam int           CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [CW-1:0] wait_cnt;
  logic [N-1:0]  next_pc;
  logic          instr_load;
  logic          pc_load;
  logic          wait_expired;

  assign pc_plus4  = pc + N'(PC_INC);
  assign imem_addr = pc;

  next_pc_calc #(
    .N (N)
  ) u_next_pc (
    .pc_plus4    (pc_plus4),
    .ext_imm     (ext_imm),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jump_target (jump_target),
    .next_pc     (next_pc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    instr_load   = 1'b0;
    pc_load      = 1'b0;
    wait_expired = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_next = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_load = 1'b1;
          state_next = S_EXEC;
        end else if (wait_cnt == WAIT_LAST) begin
          wait_expired = 1'b1;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          pc_load    = 1'b1;
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // A timed-out request stays at the same pc; only the wait count restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      instr     <= NOP_INSTR;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (pc_load) begin
        pc <= next_pc;
      end
      if (instr_load) begin
        instr <= imem_rdata;
      end
      if (instr_load || wait_expired) begin
        wait_cnt <= '0;
      end else if (imem_req) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_expired) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: expected fetch addresses queue up as
// each execute cycle ends and are compared when the controller requests.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ext_imm;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [25:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  pc_fetch_ctrl #(
    .N        (32),
    .RESET_PC (32'h0),
    .TIMEOUT  (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ext_imm     (ext_imm),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jump_target (jump_target),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jump;
    logic        branch;
    logic        zero;
    logic [31:0] ext_imm;
    logic [25:0] tgt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] rdata);
    int          waited;
    logic [31:0] exp_addr;
    waited   = 0;
    exp_addr = 32'hDEAD_BEEF;
    while (!imem_req && waited < 20) begin
      tick();
      waited++;
    end
    check("fetch_req_seen", 32'(imem_req), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_underflow: got empty queue expected an address");
    end else begin
      exp_addr = exp_q.pop_front();
    end
    check("imem_addr", imem_addr, exp_addr);
    check("pc", pc, exp_addr);
    check("pc_plus4", pc_plus4, exp_addr + 32'd4);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_0BAD;
    check("instr", instr, rdata);
    check("instr_valid_exec", 32'(instr_valid), 32'd1);
    check("imem_req_exec", 32'(imem_req), 32'd0);
  endtask

  task automatic exec_step(input logic j, input logic b, input logic z,
                           input logic [31:0] imm, input logic [25:0] tgt,
                           input logic [31:0] exp_next);
    jump        = j;
    branch      = b;
    zero        = z;
    ext_imm     = imm;
    jump_target = tgt;
    stall       = 1'b0;
    exp_q.push_back(exp_next);
    tick();
    jump    = 1'b0;
    branch  = 1'b0;
    zero    = 1'b0;
    ext_imm = 32'h0;
    check("exec_exit_req", 32'(imem_req), 32'd1);
    check("exec_exit_valid", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 26'h0,  32'h0000_0004};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 26'h0,  32'h0000_0008};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 26'h4,  32'h0000_0010};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 26'h0,  32'h0000_000C};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 26'h4,  32'h0000_0010};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0,  32'h0000_0014};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h03FF_FFFC, 26'h0,  32'h1000_0008};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 26'h40, 32'h1000_0100};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h3BFF_FFBE, 26'h0,  32'hFFFF_FFFC};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 26'h7,  32'h0000_0000};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h0000_0005, 26'h9,  32'h0000_0018};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'hC000_0001, 26'h0,  32'h0000_0020};

    reset       = 1'b1;
    ext_imm     = 32'h0;
    branch      = 1'b0;
    zero        = 1'b0;
    jump        = 1'b0;
    jump_target = 26'h0;
    stall       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);

    reset = 1'b0;
    exp_q.push_back(32'h0);
    check("idle_req", 32'(imem_req), 32'd0);
    tick();
    check("idle_one_cycle", 32'(imem_req), 32'd1);
    do_fetch(32'hA000_00FF);

    for (int i = 0; i < 12; i++) begin
      exec_step(vecs[i].jump, vecs[i].branch, vecs[i].zero,
                vecs[i].ext_imm, vecs[i].tgt, vecs[i].exp_pc);
      do_fetch(32'hA000_0000 + 32'(i));
    end

    // Stall in execute at pc 0x20; a stray ack must not disturb instr.
    stall      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", instr, 32'hA000_000B);
      check("stall_pc", pc, 32'h0000_0020);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    exp_q.push_back(32'h0000_0024);
    stall = 1'b0;
    tick();
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_pc", pc, 32'h0000_0024);

    // Withhold ack: flag must rise exactly after the 15th waiting edge.
    for (int i = 1; i < 15; i++) begin
      tick();
      check("wait_fetch_err", 32'(fetch_err), 32'd0);
      check("wait_addr", imem_addr, 32'h0000_0024);
    end
    tick();
    check("timeout_fetch_err", 32'(fetch_err), 32'd1);
    check("timeout_req", 32'(imem_req), 32'd1);
    check("timeout_addr", imem_addr, 32'h0000_0024);
    tick();
    check("reissue_req", 32'(imem_req), 32'd1);
    do_fetch(32'h1234_5678);
    check("sticky_fetch_err", 32'(fetch_err), 32'd1);

    exec_step(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0000_0028);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h7777_7777;
    tick();
    check("rst_req_pc", pc, 32'h0);
    check("rst_req_instr", instr, 32'h0);
    check("rst_req_req", 32'(imem_req), 32'd0);
    check("rst_req_valid", 32'(instr_valid), 32'd0);
    check("rst_req_fetch_err", 32'(fetch_err), 32'd0);
    reset    = 1'b0;
    imem_ack = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    do_fetch(32'hCAFE_F00D);
    check("post_rst_fetch_err", 32'(fetch_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
